// File: rtl/up_down_counter255_tester_pkg.sv
// Shared constants and types for the up/down counter tester: register map,
// reset defaults and sequencer state encodings.
package up_down_counter255_tester_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] ADDR_PLR = 2'b00;
    localparam logic [1:0] ADDR_ULR = 2'b01;
    localparam logic [1:0] ADDR_LLR = 2'b10;
    localparam logic [1:0] ADDR_CCR = 2'b11;

    localparam logic [DATA_W-1:0] PLR_RST = 8'd1;
    localparam logic [DATA_W-1:0] ULR_RST = 8'd255;
    localparam logic [DATA_W-1:0] LLR_RST = 8'd0;
    localparam logic [DATA_W-1:0] CCR_RST = 8'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_END} run_state_t;
    typedef enum logic [1:0] {PH_UP1, PH_DOWN, PH_UP2} phase_t;

endpackage

// File: rtl/udc_regfile.sv
// Four write-once configuration registers (PLR/ULR/LLR/CCR) with a
// combinational read mux. Flags re-arm on reset or at the end of a run.
module udc_regfile
    import up_down_counter255_tester_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              clr_flags,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] plr,
    output logic [DATA_W-1:0] ulr,
    output logic [DATA_W-1:0] llr,
    output logic [DATA_W-1:0] ccr,
    output logic [DATA_W-1:0] rdata
);

    logic [3:0] written;

    always_ff @(posedge clk) begin
        if (reset) begin
            plr     <= PLR_RST;
            ulr     <= ULR_RST;
            llr     <= LLR_RST;
            ccr     <= CCR_RST;
            written <= '0;
        end else if (clr_flags) begin
            written <= '0;
        end else if (wr_en && !written[addr]) begin
            // Only the first write per register sticks until the flags re-arm
            written[addr] <= 1'b1;
            case (addr)
                ADDR_PLR: plr <= wdata;
                ADDR_ULR: ulr <= wdata;
                ADDR_LLR: llr <= wdata;
                default:  ccr <= wdata;
            endcase
        end
    end

    always_comb begin
        rdata = plr;
        case (addr)
            ADDR_PLR: rdata = plr;
            ADDR_ULR: rdata = ulr;
            ADDR_LLR: rdata = llr;
            default:  rdata = ccr;
        endcase
    end

endmodule

// File: rtl/up_down_counter255_tester.sv
// Bus-programmed up/down counter: after a single-cycle start pulse it sweeps
// PLR -> ULR -> LLR -> PLR, CCR times, then pulses ec.
module up_down_counter255_tester
    import up_down_counter255_tester_pkg::*;
(
    inout  wire  [DATA_W-1:0] Din,
    input  logic              clk,
    input  logic              ncs,
    input  logic              nrd,
    input  logic              nwr,
    input  logic              start_in,
    input  logic              reset,
    input  logic              A0,
    input  logic              A1,
    output logic [DATA_W-1:0] count,
    output logic              err,
    output logic              ec,
    output logic              dir
);

    logic [1:0]        addr;
    logic              bus_wr;
    logic              bus_rd;
    logic [DATA_W-1:0] plr, ulr, llr, ccr, rdata;
    logic              clr_flags;

    run_state_t        state, nxt_state;
    phase_t            phase, nxt_phase;
    logic [DATA_W-1:0] cnt_q, nxt_cnt;
    logic [DATA_W-1:0] rep_left, nxt_rep;
    logic              dir_q, nxt_dir;
    logic              count_oe;
    logic              dir_oe;
    logic              start_prev;
    logic              pulse_ok;
    logic              start_acc;
    logic              end_rep;

    assign addr   = {A1, A0};
    assign bus_wr = !ncs && !nwr && nrd;
    assign bus_rd = !ncs && nwr && !nrd;

    udc_regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (bus_wr && (state == ST_IDLE)),
        .clr_flags (clr_flags),
        .addr      (addr),
        .wdata     (Din),
        .plr       (plr),
        .ulr       (ulr),
        .llr       (llr),
        .ccr       (ccr),
        .rdata     (rdata)
    );

    assign Din   = bus_rd   ? rdata : {DATA_W{1'bz}};
    assign count = count_oe ? cnt_q : {DATA_W{1'bz}};
    assign dir_oe = (state != ST_IDLE);
    assign dir   = dir_oe   ? dir_q : 1'bz;

    // A start is qualified on its single high edge and accepted on the next
    // edge only if start_in has already dropped; longer pulses never qualify.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_prev <= 1'b0;
            pulse_ok   <= 1'b0;
            err        <= 1'b0;
        end else begin
            start_prev <= start_in;
            pulse_ok   <= start_in && !start_prev && !ncs && !err && (state == ST_IDLE);
            err        <= (plr < llr) || (plr > ulr);
        end
    end

    assign start_acc = pulse_ok && !start_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            count_oe <= 1'b0;
        end else begin
            state <= nxt_state;
            if (nxt_state == ST_RUN)
                count_oe <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        phase    <= nxt_phase;
        cnt_q    <= nxt_cnt;
        rep_left <= nxt_rep;
        dir_q    <= nxt_dir;
    end

    always_comb begin
        nxt_state = state;
        nxt_phase = phase;
        nxt_cnt   = cnt_q;
        nxt_rep   = rep_left;
        nxt_dir   = dir_q;
        clr_flags = 1'b0;
        end_rep   = 1'b0;
        ec        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_acc) begin
                    nxt_dir = 1'b1;
                    if (ccr == '0) begin
                        nxt_state = ST_END;
                    end else begin
                        nxt_state = ST_RUN;
                        nxt_cnt   = plr;
                        nxt_phase = PH_UP1;
                        nxt_rep   = ccr;
                    end
                end
            end
            ST_RUN: begin
                // Empty phases fall straight through to the next one
                case (phase)
                    PH_UP1: begin
                        if (cnt_q != ulr) begin
                            nxt_cnt = cnt_q + 8'd1;
                        end else if (cnt_q != llr) begin
                            nxt_cnt   = cnt_q - 8'd1;
                            nxt_dir   = 1'b0;
                            nxt_phase = PH_DOWN;
                        end else if (cnt_q != plr) begin
                            nxt_cnt   = cnt_q + 8'd1;
                            nxt_phase = PH_UP2;
                        end else begin
                            end_rep = 1'b1;
                        end
                    end
                    PH_DOWN: begin
                        if (cnt_q != llr) begin
                            nxt_cnt = cnt_q - 8'd1;
                        end else if (cnt_q != plr) begin
                            nxt_cnt   = cnt_q + 8'd1;
                            nxt_dir   = 1'b1;
                            nxt_phase = PH_UP2;
                        end else begin
                            end_rep = 1'b1;
                        end
                    end
                    default: begin
                        if (cnt_q != plr)
                            nxt_cnt = cnt_q + 8'd1;
                        else
                            end_rep = 1'b1;
                    end
                endcase
                if (end_rep) begin
                    if (rep_left > 8'd1) begin
                        nxt_rep   = rep_left - 8'd1;
                        nxt_cnt   = plr;
                        nxt_dir   = 1'b1;
                        nxt_phase = PH_UP1;
                    end else begin
                        nxt_state = ST_END;
                    end
                end
            end
            ST_END: begin
                ec        = 1'b1;
                clr_flags = 1'b1;
                nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_up_down_counter255_tester.sv
// Randomized and directed bench for up_down_counter255_tester against a
// queue-based model of the expected count/dir sequence.
module tb_up_down_counter255_tester;

    logic       clk = 1'b0;
    logic       ncs = 1'b1, nrd = 1'b1, nwr = 1'b1, start_in = 1'b0, reset = 1'b0;
    logic       A0 = 1'b0, A1 = 1'b0;
    logic       tb_drv = 1'b0;
    logic [7:0] tb_data = 8'd0;
    wire  [7:0] Din;
    wire  [7:0] count;
    wire        err, ec, dir;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_cnt[$];
    logic       exp_dir[$];

    assign Din = tb_drv ? tb_data : 8'bz;

    always #5 clk = ~clk;

    up_down_counter255_tester dut (
        .Din(Din), .clk(clk), .ncs(ncs), .nrd(nrd), .nwr(nwr),
        .start_in(start_in), .reset(reset), .A0(A0), .A1(A1),
        .count(count), .err(err), .ec(ec), .dir(dir)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] v);
        {A1, A0} = a;
        tb_data = v;
        tb_drv = 1'b1;
        ncs = 1'b0; nwr = 1'b0; nrd = 1'b1;
        tick();
        nwr = 1'b1; ncs = 1'b1; tb_drv = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] v);
        {A1, A0} = a;
        tb_drv = 1'b0;
        ncs = 1'b0; nwr = 1'b1; nrd = 1'b0;
        #1;
        v = Din;
        nrd = 1'b1; ncs = 1'b1;
        #1;
    endtask

    // Expected sequence straight from the run rules: per repetition the PLR
    // load, then each value on the way up to ULR, down to LLR, back up to PLR.
    task automatic build_model(input int p, input int u, input int l, input int c);
        exp_cnt.delete();
        exp_dir.delete();
        for (int r = 0; r < c; r++) begin
            exp_cnt.push_back(8'(p)); exp_dir.push_back(1'b1);
            for (int v = p + 1; v <= u; v++) begin exp_cnt.push_back(8'(v)); exp_dir.push_back(1'b1); end
            for (int v = u - 1; v >= l; v--) begin exp_cnt.push_back(8'(v)); exp_dir.push_back(1'b0); end
            for (int v = l + 1; v <= p; v++) begin exp_cnt.push_back(8'(v)); exp_dir.push_back(1'b1); end
        end
    endtask

    task automatic pulse_start();
        ncs = 1'b0; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] v;
        logic [7:0] defs [4];
        defs = '{8'd1, 8'd255, 8'd0, 8'd0};
        do_reset();
        n_tests++;
        if (ec !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags ec=%b err=%b expected 0/0", ec, err);
        end
        n_tests++;
        if (dut.count_oe !== 1'b0 || dut.dir_oe !== 1'b0) begin
            n_fail++; $display("FAIL reset_hiz count_oe=%b dir_oe=%b expected 0/0", dut.count_oe, dut.dir_oe);
        end
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), v);
            n_tests++;
            if (v !== defs[a]) begin
                n_fail++; $display("FAIL reset_reg[%0d] got %0d expected %0d", a, v, defs[a]);
            end
        end
    endtask

    task automatic test_run(input string name, input logic [7:0] p, input logic [7:0] u,
                            input logic [7:0] l, input logic [7:0] c);
        logic [7:0] v;
        logic [7:0] vals [4];
        int         n;
        vals = '{p, u, l, c};
        for (int a = 0; a < 4; a++) write_reg(2'(a), vals[a]);
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), v);
            n_tests++;
            if (v !== vals[a]) begin
                n_fail++; $display("FAIL %s_readback[%0d] got %0d expected %0d", name, a, v, vals[a]);
            end
        end
        tick();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL %s_err got %b expected 0", name, err);
        end
        build_model(int'(p), int'(u), int'(l), int'(c));
        n = exp_cnt.size();
        pulse_start();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                // Random ncs must not pause the run; a write attempt mid-run must be ignored
                if (n > 6 && i == 2) begin
                    {A1, A0} = 2'b00; tb_data = p ^ 8'h55; tb_drv = 1'b1;
                    ncs = 1'b0; nwr = 1'b0;
                end else if (n > 6 && i == 4) begin
                    nwr = 1'b1; tb_drv = 1'b0; ncs = 1'b1;
                end else if (nwr) begin
                    ncs = 1'($urandom_range(0, 1));
                end
                tick();
            end
            n_tests++;
            if (count !== exp_cnt[i] || dir !== exp_dir[i] || ec !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_step[%0d] count=%0d dir=%b ec=%b expected %0d/%b/0",
                         name, i, count, dir, ec, exp_cnt[i], exp_dir[i]);
            end
        end
        nwr = 1'b1; tb_drv = 1'b0; ncs = 1'b1;
        if (n > 0) tick();
        n_tests++;
        if (ec !== 1'b1) begin
            n_fail++; $display("FAIL %s_ec got %b expected 1", name, ec);
        end
        tick();
        n_tests++;
        if (ec !== 1'b0 || dut.dir_oe !== 1'b0) begin
            n_fail++; $display("FAIL %s_after_ec ec=%b dir_oe=%b expected 0/0", name, ec, dut.dir_oe);
        end
        if (n > 0) begin
            n_tests++;
            if (count !== exp_cnt[n-1]) begin
                n_fail++; $display("FAIL %s_hold count=%0d expected %0d", name, count, exp_cnt[n-1]);
            end
        end
        read_reg(2'b00, v);
        n_tests++;
        if (v !== p) begin
            n_fail++; $display("FAIL %s_plr_after got %0d expected %0d", name, v, p);
        end
    endtask

    task automatic test_err();
        do_reset();
        write_reg(2'b00, 8'd20);
        write_reg(2'b01, 8'd15);
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL err_registered got %b expected 0", err);
        end
        tick();
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL err_set got %b expected 1", err);
        end
        pulse_start();
        ncs = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (dut.count_oe !== 1'b0 || ec !== 1'b0) begin
                n_fail++; $display("FAIL err_no_run[%0d] count_oe=%b ec=%b expected 0/0", i, dut.count_oe, ec);
            end
        end
    endtask

    task automatic test_write_once_long_pulse();
        logic [7:0] v;
        do_reset();
        write_reg(2'b00, 8'd10);
        write_reg(2'b00, 8'd20);
        read_reg(2'b00, v);
        n_tests++;
        if (v !== 8'd10) begin
            n_fail++; $display("FAIL write_once got %0d expected 10", v);
        end
        tick();
        ncs = 1'b0; start_in = 1'b1;
        repeat (3) tick();
        start_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (dut.count_oe !== 1'b0 || ec !== 1'b0) begin
                n_fail++; $display("FAIL long_pulse[%0d] count_oe=%b ec=%b expected 0/0", i, dut.count_oe, ec);
            end
        end
        ncs = 1'b1;
    endtask

    task automatic test_ncs_blocks_start();
        do_reset();
        tick();
        ncs = 1'b1; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (dut.count_oe !== 1'b0 || ec !== 1'b0) begin
                n_fail++; $display("FAIL ncs_block[%0d] count_oe=%b ec=%b expected 0/0", i, dut.count_oe, ec);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] v;
        logic [7:0] defs [4];
        defs = '{8'd1, 8'd255, 8'd0, 8'd0};
        do_reset();
        write_reg(2'b00, 8'd0);
        write_reg(2'b01, 8'd255);
        write_reg(2'b10, 8'd0);
        write_reg(2'b11, 8'd3);
        tick();
        pulse_start();
        ncs = 1'b1;
        repeat (20) tick();
        n_tests++;
        if (count !== 8'd20 || dir !== 1'b1) begin
            n_fail++; $display("FAIL midrun_pre count=%0d dir=%b expected 20/1", count, dir);
        end
        do_reset();
        n_tests++;
        if (dut.count_oe !== 1'b0 || dut.dir_oe !== 1'b0 || ec !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset count_oe=%b dir_oe=%b ec=%b err=%b expected 0/0/0/0",
                     dut.count_oe, dut.dir_oe, ec, err);
        end
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), v);
            n_tests++;
            if (v !== defs[a]) begin
                n_fail++; $display("FAIL midrun_reg[%0d] got %0d expected %0d", a, v, defs[a]);
            end
        end
        repeat (3) tick();
        n_tests++;
        if (dut.count_oe !== 1'b0 || ec !== 1'b0) begin
            n_fail++; $display("FAIL midrun_idle count_oe=%b ec=%b expected 0/0", dut.count_oe, ec);
        end
    endtask

    task automatic test_random_runs();
        logic [7:0] l, u, p, c;
        for (int k = 0; k < 6; k++) begin
            l = 8'($urandom_range(0, 240));
            u = l + 8'($urandom_range(0, 12));
            p = 8'($urandom_range(int'(l), int'(u)));
            c = 8'($urandom_range(0, 3));
            test_run("random", p, u, l, c);
        end
    endtask

    initial begin
        test_reset();
        test_run("readback_run", 8'd10, 8'd15, 8'd5, 8'd2);
        test_run("single_rep", 8'd1, 8'd5, 8'd1, 8'd1);
        test_run("flat", 8'd5, 8'd5, 8'd5, 8'd1);
        test_run("ccr_zero", 8'd7, 8'd9, 8'd3, 8'd0);
        test_random_runs();
        test_run("full_range", 8'd0, 8'd255, 8'd0, 8'd1);
        test_run("top_edge", 8'd255, 8'd255, 8'd0, 8'd1);
        test_err();
        test_write_once_long_pulse();
        test_ncs_blocks_start();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout tests_run=%0d expected completion", n_tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/up_down_counter255_tester.md
UP_DOWN_COUNTER255_TESTER -- requirements
Module: up_down_counter255_tester

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; no other clock or reset domain exists.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 Din  inout  8  bidirectional data bus: written into registers, driven on reads, else high-Z.
REQ-005 ncs  input  1  active-low chip select; 1 blocks bus write, bus read and start.
REQ-006 nrd  input  1  active-low read strobe.
REQ-007 nwr  input  1  active-low write strobe.
REQ-008 start_in  input  1  active-high start pulse.
REQ-009 A0, A1  input  1 each  register address {A1,A0}: 00 PLR (preload), 01 ULR (upper limit), 10 LLR (lower limit), 11 CCR (cycle count).
REQ-010 count  output  8  counter value.
REQ-011 err  output  1  1 = illegal limits (PLR<LLR or PLR>ULR).
REQ-012 ec  output  1  one-clock end-of-run pulse.
REQ-013 dir  output  1  1 = counting up, 0 = counting down, Z when idle.
REQ-014 Positional port order SHALL be Din, clk, ncs, nrd, nwr, start_in, reset, A0, A1, count, err, ec, dir.

Function
REQ-015 Write: at posedge with ncs=0, nwr=0, nrd=1, no reset: Din loads the addressed register.
REQ-016 Each register SHALL accept only the first write after reset or after an ec pulse; later writes are ignored until the write-once flags clear.
REQ-017 Read: while ncs=0, nwr=1, nrd=0: Din driven with the addressed register combinationally; otherwise Din high-Z.
REQ-018 err SHALL be registered each posedge from the current register values, independent of ncs.
REQ-019 Start accepted only when ncs=0 and err=0 and start_in is high at exactly one rising edge; a pulse spanning two or more rising edges SHALL be discarded.
REQ-020 Run, starting at the first posedge after start_in falls, repeated CCR times: count=PLR; then ULR-PLR up-steps (+1); then ULR-LLR down-steps (-1); then PLR-LLR up-steps; one value per clock.
REQ-021 dir=1 during up phases and the initial PLR load; dir=0 during the down phase.
REQ-022 Each repetition SHALL begin by reloading count=PLR.
REQ-023 After the last step, ec=1 for exactly one clock; then dir goes Z, write-once flags clear, and count holds its last value.
REQ-024 CCR=0: no counting; ec pulses on the clock after the start is accepted.
REQ-025 PLR=LLR=ULR: each repetition is a single count=PLR clock.
REQ-026 Bus writes and starts are ignored while a run is active.
REQ-027 ncs=1 does not pause an active run.
REQ-028 All arithmetic is 8-bit unsigned; with err=0, count never wraps.

Reset
REQ-029 reset=1 at posedge SHALL set PLR=1, ULR=255, LLR=0, CCR=0, clear the write-once flags, set ec=0 and err=0, set count=Z and dir=Z, and abort any run, including mid-run.

Structure
REQ-030 A shared package SHALL hold the register address constants (PLR/ULR/LLR/CCR) and the reset defaults (1, 255, 0, 0).
REQ-031 One sub-module, udc_regfile, SHALL hold the four write-once registers and the read mux.
REQ-032 Start detection and the run sequencer SHALL live in the top module.

Verification
REQ-033 Write PLR=10, ULR=15, LLR=5, CCR=2; read back 10/15/5/2; start -> count sequence 10..15..5..10, run twice, err=0, then one ec pulse.
REQ-034 PLR=1, ULR=5, LLR=1, CCR=1 -> count 1,2,3,4,5,4,3,2,1 with dir 1×5, 0×4, then ec.
REQ-035 PLR=ULR=LLR=5, CCR=1 -> count=5 for one clock, then ec.
REQ-036 PLR=20, ULR=15 -> err=1 next clock; start ignored, count stays Z.
REQ-037 Second write to PLR before ec is ignored (readback shows the first value); start_in high for 3 clocks -> no run.
REQ-038 reset=1 mid-run -> count Z, dir Z, ec 0, registers back to 1/255/0/0.
